// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte physical layer.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;
   localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'h00;

   typedef enum logic {
      StIdle,
      StActive
   } spi_phy_state_e;

endpackage

// File: rtl/spi_byte_phy_if.sv
// Byte handshake between the SPI PHY and the downstream SPI-to-Wishbone stage.
interface spi_byte_phy_if;
   import spi_pkg::*;

   logic [SPI_BYTE_W-1:0] rx_data;
   logic                  rx_stb;
   logic [SPI_BYTE_W-1:0] tx_data;
   logic                  tx_stb;
   logic                  tx_underrun;

   modport master (
      output rx_data,
      output rx_stb,
      output tx_underrun,
      input  tx_data,
      input  tx_stb
   );

   modport slave (
      input  rx_data,
      input  rx_stb,
      input  tx_underrun,
      output tx_data,
      output tx_stb
   );

endinterface

// File: rtl/spi_sync.sv
// Multi-bit, multi-stage flop synchroniser with a configurable reset level.
module spi_sync #(
   parameter int unsigned     WIDTH     = 1,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stages_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages_q <= {DEPTH{RESET_VAL}};
      end else begin
         stages_q <= {stages_q[DEPTH-2:0], d};
      end
   end

   assign q = stages_q[DEPTH-1];

endmodule

// File: rtl/spi_byte_phy.sv
// SPI mode 0 peripheral PHY: oversampled pins, MSB-first byte deserialiser and
// serialiser with a one-byte transmit holding register.
module spi_byte_phy
   import spi_pkg::*;
#(
   parameter int unsigned           SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = SPI_FILL_BYTE
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           spi_sck,
   input  logic           spi_csn,
   input  logic           spi_sdi,
   output logic           spi_sdo,
   output logic           spi_sdo_oe,
   spi_byte_phy_if.master byte_if
);

   logic [2:0] pins_s;
   logic       sck_s, csn_s, sdi_s;
   logic       sck_q, csn_q;
   logic       sck_rise, sck_fall, cs_start, cs_end;

   spi_phy_state_e        state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [SPI_BYTE_W-1:0] shift_in_q, shift_in_d;
   logic [SPI_BYTE_W-1:0] shift_out_q, shift_out_d;
   logic [SPI_BYTE_W-1:0] tx_next_q, tx_next_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  rx_pend_q, rx_pend_d;
   logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
   logic                  rx_stb_q, rx_stb_d;
   logic                  underrun_q, underrun_d;

   // Idle levels: sdi=0, csn=1, sck=0.
   spi_sync #(
      .WIDTH     (3),
      .DEPTH     (SYNC_STAGES),
      .RESET_VAL (3'b010)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({spi_sdi, spi_csn, spi_sck}),
      .q     (pins_s)
   );

   assign sck_s = pins_s[0];
   assign csn_s = pins_s[1];
   assign sdi_s = pins_s[2];

   assign sck_rise = sck_s & ~sck_q;
   assign sck_fall = ~sck_s & sck_q;
   assign cs_start = ~csn_s & csn_q;
   assign cs_end   = csn_s & ~csn_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_in_d  = shift_in_q;
      shift_out_d = shift_out_q;
      tx_next_d   = tx_next_q;
      tx_valid_d  = tx_valid_q;
      rx_pend_d   = 1'b0;
      rx_data_d   = rx_pend_q ? shift_in_q : rx_data_q;
      rx_stb_d    = rx_pend_q;
      underrun_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cs_start) begin
               state_d     = StActive;
               bit_cnt_d   = '0;
               shift_out_d = FILL_BYTE;
               tx_valid_d  = 1'b0;
            end
         end
         StActive: begin
            if (cs_end) begin
               state_d    = StIdle;
               bit_cnt_d  = '0;
               tx_valid_d = 1'b0;
            end else begin
               if (byte_if.tx_stb) begin
                  tx_next_d  = byte_if.tx_data;
                  tx_valid_d = 1'b1;
               end
               if (sck_rise) begin
                  shift_in_d = {shift_in_q[SPI_BYTE_W-2:0], sdi_s};
                  bit_cnt_d  = bit_cnt_q + 3'd1;
                  rx_pend_d  = (bit_cnt_q == 3'd7);
               end
               if (sck_fall) begin
                  if (bit_cnt_q != 3'd0) begin
                     shift_out_d = {shift_out_q[SPI_BYTE_W-2:0], 1'b0};
                  end else begin
                     // A strobe arriving on the boundary cycle is sent directly.
                     if (byte_if.tx_stb) begin
                        shift_out_d = byte_if.tx_data;
                     end else if (tx_valid_q) begin
                        shift_out_d = tx_next_q;
                     end else begin
                        shift_out_d = FILL_BYTE;
                        underrun_d  = 1'b1;
                     end
                     tx_valid_d = 1'b0;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q       <= 1'b0;
         csn_q       <= 1'b1;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= FILL_BYTE;
         tx_next_q   <= FILL_BYTE;
         tx_valid_q  <= 1'b0;
         rx_pend_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_stb_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sck_q       <= sck_s;
         csn_q       <= csn_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_in_q  <= shift_in_d;
         shift_out_q <= shift_out_d;
         tx_next_q   <= tx_next_d;
         tx_valid_q  <= tx_valid_d;
         rx_pend_q   <= rx_pend_d;
         rx_data_q   <= rx_data_d;
         rx_stb_q    <= rx_stb_d;
         underrun_q  <= underrun_d;
      end
   end

   assign spi_sdo_oe          = (state_q == StActive);
   assign spi_sdo             = (state_q == StActive) & shift_out_q[SPI_BYTE_W-1];
   assign byte_if.rx_data     = rx_data_q;
   assign byte_if.rx_stb      = rx_stb_q;
   assign byte_if.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_byte_phy.sv
// Directed bench for spi_byte_phy: acts as SPI controller and downstream stage.
module tb_spi_byte_phy;
   import spi_pkg::*;

   localparam int unsigned SYNC = 2;
   localparam int          HALF = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic spi_sck, spi_csn, spi_sdi;
   logic spi_sdo, spi_sdo_oe;

   spi_byte_phy_if byte_if ();

   spi_byte_phy #(
      .SYNC_STAGES (SYNC),
      .FILL_BYTE   (8'h00)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_sck    (spi_sck),
      .spi_csn    (spi_csn),
      .spi_sdi    (spi_sdi),
      .spi_sdo    (spi_sdo),
      .spi_sdo_oe (spi_sdo_oe),
      .byte_if    (byte_if)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Monitor state
   int       cyc = 0;
   int       rx_cnt = 0;
   int       und_cnt = 0;
   int       oe_cnt = 0;
   int       rx_cyc = 0;
   logic [7:0] last_rx = 8'h00;
   int       rise_cyc = 0;

   // Responder control
   logic       resp_en = 1'b0;
   logic [7:0] resp_byte = 8'h00;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (byte_if.rx_stb === 1'b1) begin
            rx_cnt++;
            last_rx = byte_if.rx_data;
            rx_cyc  = cyc;
         end
         if (byte_if.tx_underrun === 1'b1) und_cnt++;
         if (spi_sdo_oe === 1'b1) oe_cnt++;
      end
   end

   // Downstream stage: answers rx_stb with tx_stb one cycle later.
   initial begin
      byte_if.tx_stb  = 1'b0;
      byte_if.tx_data = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         byte_if.tx_stb = 1'b0;
         if (resp_en && byte_if.rx_stb === 1'b1) begin
            byte_if.tx_data = resp_byte;
            byte_if.tx_stb  = 1'b1;
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_low();
      spi_csn = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic cs_high();
      wait_clks(HALF);
      spi_csn = 1'b1;
      wait_clks(2 * HALF);
   endtask

   // Clocks nbits of mosi (MSB first), sampling SDO just before each rising edge.
   task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      logic [7:0] m;
      m = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = mosi[7-i];
         wait_clks(HALF);
         m = {m[6:0], spi_sdo};
         spi_sck  = 1'b1;
         rise_cyc = cyc;
         wait_clks(HALF);
         spi_sck = 1'b0;
      end
      miso = m;
   endtask

   task automatic test_reset();
      int rx0, oe0;
      rst_n   = 1'b0;
      spi_sck = 1'b0;
      spi_csn = 1'b1;
      spi_sdi = 1'b0;
      wait_clks(3);
      tests++; if (spi_sdo !== 1'b0) begin fails++; $display("FAIL reset_sdo got %b want 0", spi_sdo); end
      tests++; if (spi_sdo_oe !== 1'b0) begin fails++; $display("FAIL reset_oe got %b want 0", spi_sdo_oe); end
      tests++; if (byte_if.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got %h want 00", byte_if.rx_data); end
      tests++; if (byte_if.rx_stb !== 1'b0) begin fails++; $display("FAIL reset_rx_stb got %b want 0", byte_if.rx_stb); end
      tests++; if (byte_if.tx_underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b want 0", byte_if.tx_underrun); end
      rst_n = 1'b1;
      rx0 = rx_cnt;
      oe0 = oe_cnt;
      wait_clks(100);
      tests++; if (rx_cnt - rx0 != 0) begin fails++; $display("FAIL idle_rx_stb got %0d want 0", rx_cnt - rx0); end
      tests++; if (oe_cnt - oe0 != 0) begin fails++; $display("FAIL idle_oe got %0d want 0", oe_cnt - oe0); end
   endtask

   task automatic test_single_byte();
      int rx0, und0;
      logic [7:0] miso;
      rx0  = rx_cnt;
      und0 = und_cnt;
      resp_en   = 1'b1;
      resp_byte = 8'h77;
      cs_low();
      tests++; if (spi_sdo_oe !== 1'b1) begin fails++; $display("FAIL active_oe got %b want 1", spi_sdo_oe); end
      spi_bits(8'hA5, 8, miso);
      tests++; if (rx_cyc - rise_cyc != int'(SYNC) + 2) begin fails++; $display("FAIL rx_latency got %0d want %0d", rx_cyc - rise_cyc, SYNC + 2); end
      cs_high();
      tests++; if (rx_cnt - rx0 != 1) begin fails++; $display("FAIL single_rx_count got %0d want 1", rx_cnt - rx0); end
      tests++; if (last_rx !== 8'hA5) begin fails++; $display("FAIL single_rx_data got %h want a5", last_rx); end
      tests++; if (miso !== 8'h00) begin fails++; $display("FAIL single_sdo got %h want 00", miso); end
      tests++; if (und_cnt - und0 != 0) begin fails++; $display("FAIL single_underrun got %0d want 0", und_cnt - und0); end
      tests++; if (spi_sdo_oe !== 1'b0 || spi_sdo !== 1'b0) begin fails++; $display("FAIL end_oe_sdo got %b%b want 00", spi_sdo_oe, spi_sdo); end
      tests++; if (byte_if.rx_data !== 8'hA5) begin fails++; $display("FAIL rx_hold got %h want a5", byte_if.rx_data); end
   endtask

   task automatic test_back_to_back();
      int rx0, und0;
      logic [7:0] m1, m2;
      rx0  = rx_cnt;
      und0 = und_cnt;
      resp_en   = 1'b1;
      resp_byte = 8'h3C;
      cs_low();
      spi_bits(8'h5A, 8, m1);
      spi_bits(8'hC3, 8, m2);
      cs_high();
      tests++; if (rx_cnt - rx0 != 2) begin fails++; $display("FAIL b2b_rx_count got %0d want 2", rx_cnt - rx0); end
      tests++; if (last_rx !== 8'hC3) begin fails++; $display("FAIL b2b_rx_data got %h want c3", last_rx); end
      tests++; if (m1 !== 8'h00) begin fails++; $display("FAIL b2b_sdo1 got %h want 00", m1); end
      tests++; if (m2 !== 8'h3C) begin fails++; $display("FAIL b2b_sdo2 got %h want 3c", m2); end
      tests++; if (und_cnt - und0 != 0) begin fails++; $display("FAIL b2b_underrun got %0d want 0", und_cnt - und0); end
   endtask

   task automatic test_underrun();
      int und0;
      logic [7:0] m1, m2;
      und0 = und_cnt;
      resp_en   = 1'b0;
      resp_byte = 8'hE7;
      cs_low();
      spi_bits(8'h11, 8, m1);
      resp_en = 1'b1;
      spi_bits(8'h22, 8, m2);
      cs_high();
      tests++; if (m2 !== 8'h00) begin fails++; $display("FAIL underrun_sdo2 got %h want 00", m2); end
      tests++; if (und_cnt - und0 != 1) begin fails++; $display("FAIL underrun_count got %0d want 1", und_cnt - und0); end
      tests++; if (last_rx !== 8'h22) begin fails++; $display("FAIL underrun_rx_data got %h want 22", last_rx); end
   endtask

   task automatic test_partial_abort();
      int rx0, und0;
      logic [7:0] m;
      rx0  = rx_cnt;
      und0 = und_cnt;
      resp_en   = 1'b1;
      resp_byte = 8'h99;
      cs_low();
      spi_bits(8'hFF, 5, m);
      cs_high();
      tests++; if (rx_cnt - rx0 != 0) begin fails++; $display("FAIL partial_no_stb got %0d want 0", rx_cnt - rx0); end
      cs_low();
      spi_bits(8'h12, 8, m);
      cs_high();
      tests++; if (rx_cnt - rx0 != 1) begin fails++; $display("FAIL partial_rx_count got %0d want 1", rx_cnt - rx0); end
      tests++; if (last_rx !== 8'h12) begin fails++; $display("FAIL partial_rx_data got %h want 12", last_rx); end
      tests++; if (m !== 8'h00) begin fails++; $display("FAIL partial_sdo got %h want 00", m); end
      tests++; if (und_cnt - und0 != 0) begin fails++; $display("FAIL partial_underrun got %0d want 0", und_cnt - und0); end
   endtask

   task automatic test_reset_mid_byte();
      int rx0;
      logic [7:0] m;
      rx0 = rx_cnt;
      resp_en = 1'b1;
      cs_low();
      spi_bits(8'hF0, 4, m);
      rst_n = 1'b0;
      #1;
      tests++; if (spi_sdo_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_oe got %b want 0", spi_sdo_oe); end
      tests++; if (spi_sdo !== 1'b0) begin fails++; $display("FAIL rst_mid_sdo got %b want 0", spi_sdo); end
      tests++; if (byte_if.rx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_rx_data got %h want 00", byte_if.rx_data); end
      tests++; if (byte_if.rx_stb !== 1'b0) begin fails++; $display("FAIL rst_mid_rx_stb got %b want 0", byte_if.rx_stb); end
      spi_csn = 1'b1;
      wait_clks(5);
      rst_n = 1'b1;
      wait_clks(5);
      cs_low();
      spi_bits(8'h81, 8, m);
      cs_high();
      tests++; if (rx_cnt - rx0 != 1) begin fails++; $display("FAIL rst_rx_count got %0d want 1", rx_cnt - rx0); end
      tests++; if (last_rx !== 8'h81) begin fails++; $display("FAIL rst_rx_data got %h want 81", last_rx); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_underrun();
      test_partial_abort();
      test_reset_mid_byte();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
